packet_check: RTL and testbench
===============================

Name: packet_check

Overview:
- AXI-Stream sink that receives and verifies the test-packet stream produced by the team's packet generator.
- Checks, per packet:
  - packet length, taken from the same 8-entry length table;
  - per-beat tkeep;
  - tlast placement;
  - the rolling 16-bit data pattern replicated across tdata.
- Counts good and bad packets, keeps sticky error flags, and can throttle tready to exercise upstream backpressure.
- Sits at the far end of a loopback or demo datapath, opposite the generator.

Parameters:
- DW, 128: tdata width in bits. Must be a multiple of 16, at least 16, and DW/8 a power of 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  arm checker. Sampled in IDLE only.
- stall_en  in  1  when 1, tready is throttled by an LFSR.
- axis_in_tdata  in  DW  stream data.
- axis_in_tkeep  in  DW/8  byte enables.
- axis_in_tlast  in  1  last beat of packet.
- axis_in_tvalid  in  1  beat valid.
- axis_in_tready  out  1  sink ready.
- packets_ok  out  32  count of packets received with no error.
- packets_bad  out  32  count of packets received with at least one error.
- err_flags  out  3  sticky error flags: [0] data, [1] keep, [2] length.
- busy  out  1  checker is in RUN.

Behaviour:
Reset:
- Async assert. All registers cleared: state=IDLE, counters=0, err_flags=0, tready=0, busy=0, LFSR=16'hACE1.

Length table (13-bit), indexed by 3-bit plen_idx, wraps 7->0:
- 18, 128, 1021, 205, 12, 127, 329, 256.

Derived values, DB = DW/8:
- Expected beats = ceil(len/DB).
- Partial = len mod DB.
- Expected tkeep = all ones, except on the last expected beat when partial≠0; there it is (1<<partial)-1.

States:
- IDLE:
  - tready=0.
  - On start=1: clear packets_ok, packets_bad, err_flags. Set exp_data=1, plen_idx=0, beat=1, pkt_bad=0. Go to RUN.
- RUN:
  - busy=1. No exit except reset. start is ignored.
  - tready = 1 when stall_en=0.
  - tready = lfsr[0]|lfsr[1] when stall_en=1 (75% duty).
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. Steps every clock while in RUN.

Per accepted beat (tvalid & tready), all checks are registered; flags and counters update the clock after the beat.
- Data check:
  - Every 16-bit lane of every byte-pair whose expected tkeep bytes are set must equal exp_data. Otherwise set err_flags[0] and pkt_bad.
  - Bytes with expected tkeep=0 are don't-care.
  - exp_data increments by 1 per accepted beat, mod 2^16 (65535→0), and is continuous across packets.
- Keep check:
  - tkeep ≠ expected tkeep for the current beat sets err_flags[1] and pkt_bad.
  - For beats beyond the expected count, expected tkeep = all ones.
- Length check:
  - tlast on a beat < expected beats (early), or tlast=0 on beat == expected beats (missing), sets err_flags[2] and pkt_bad.
  - After a missing tlast, the checker keeps accepting beats until tlast. The length error is flagged once per packet.
- On tlast:
  - packets_ok += !bad, or packets_bad += 1 if bad, where bad includes errors found on this same beat.
  - Then plen_idx += 1, beat = 1, pkt_bad = 0. Resync is always on tlast.
- Counters saturate at 0xFFFFFFFF.
- No accepted beat means no state change except the LFSR.
- err_flags remain set until the next start from IDLE, which requires a reset first.
- Reset mid-packet: everything returns to IDLE immediately. The partial packet is not counted.

Test Plan:
- Generator (DW=128) feeding checker, stall_en=0, 16 packets (two full table passes) → packets_ok=16, packets_bad=0, err_flags=0. Packet 0: 2 beats, beat 2 tkeep=16'h0003. Packet 2 (1021 B): 64 beats, last tkeep=16'h1FFF.
- Same run with stall_en=1 → tready observed low on some cycles. Results identical: 16 ok, 0 bad.
- Corrupt one lane of beat 5 of packet 1 (128 B, 8 beats) → err_flags=3'b001, packets_bad=1. All other packets ok, so after 8 packets packets_ok=7.
- Drive packet 0 with tlast on beat 1 (early) → err_flags[2]=1, packets_bad=1. Next packet is checked against 128 B with exp_data continuing at 2 and passes.
- Packet 4 (12 B) sent with tkeep=16'hFFFF on its only beat → err_flags[1]=1, packets_bad increments by exactly 1.
- Assert reset mid-packet 2, release, pulse start, rerun 8 clean packets → packets_ok=8, packets_bad=0, err_flags=0, busy=1.

Source files
------------

// File: rtl/packet_check.sv
`default_nettype none
// ============================================================================
//  Module      : packet_check
//  Description : AXI-Stream sink that checks the test-packet stream from the
//                packet generator. Per packet it verifies the length (taken
//                from an 8-entry table), the per-beat tkeep, the tlast
//                position and a rolling 16-bit data pattern replicated across
//                tdata. Counts good and bad packets, keeps sticky error flags
//                and can throttle tready with an LFSR to exercise upstream
//                backpressure.
//  Ports       : clk, reset          - clock, async active-high reset
//                start               - arm checker (sampled in IDLE only)
//                stall_en            - throttle tready with the LFSR
//                axis_in_*           - AXI-Stream slave (tdata/tkeep/tlast/
//                                      tvalid in, tready out)
//                packets_ok/bad      - saturating packet counters
//                err_flags           - sticky {length, keep, data} errors
//                busy                - checker is in RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module packet_check #(
    parameter int DW = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stall_en,
    input  logic [DW-1:0]     axis_in_tdata,
    input  logic [DW/8-1:0]   axis_in_tkeep,
    input  logic              axis_in_tlast,
    input  logic              axis_in_tvalid,
    output logic              axis_in_tready,
    output logic [31:0]       packets_ok,
    output logic [31:0]       packets_bad,
    output logic [2:0]        err_flags,
    output logic              busy
);

    localparam int DB    = DW / 8;
    localparam int LANES = DW / 16;
    localparam int KW    = $clog2(DB);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [15:0] c_lfsr_seed = 16'hACE1;

    logic [0:0]     r_state;
    logic [0:0]     w_state_nxt;
    logic [15:0]    r_lfsr;
    logic [31:0]    r_ok;
    logic [31:0]    r_bad;
    logic [2:0]     r_err;
    logic [15:0]    r_exp_data;
    logic [2:0]     r_plen_idx;
    logic [12:0]    r_beat;
    logic           r_pkt_bad;

    // Packet length table, indexed by the packet sequence number mod 8
    function automatic logic [12:0] f_len(input logic [2:0] idx);
        case (idx)
            3'd0:    f_len = 13'd18;
            3'd1:    f_len = 13'd128;
            3'd2:    f_len = 13'd1021;
            3'd3:    f_len = 13'd205;
            3'd4:    f_len = 13'd12;
            3'd5:    f_len = 13'd127;
            3'd6:    f_len = 13'd329;
            default: f_len = 13'd256;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Expected shape of the current beat
    // ------------------------------------------------------------------
    logic [12:0]    w_len;
    logic [13:0]    w_len_rnd;
    logic [12:0]    w_exp_beats;
    logic [KW-1:0]  w_partial;
    logic           w_last_exp;
    logic [DB-1:0]  w_exp_keep;

    assign w_len       = f_len(r_plen_idx);
    assign w_len_rnd   = {1'b0, w_len} + 14'(DB - 1);
    assign w_exp_beats = 13'(w_len_rnd >> KW);
    assign w_partial   = w_len[KW-1:0];
    assign w_last_exp  = (r_beat == w_exp_beats);
    // Beats past the expected count also expect all ones
    assign w_exp_keep  = (w_last_exp && (w_partial != '0)) ?
                         ~({DB{1'b1}} << w_partial) : {DB{1'b1}};

    // Byte-wise data compare: a lane that is only half kept still checks
    // its kept byte, so comparisons are done per byte against the
    // little-endian halves of the expected 16-bit word.
    logic [DB-1:0]  w_byte_bad;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_byte_bad[2*gi]   = w_exp_keep[2*gi] &&
                                    (axis_in_tdata[16*gi +: 8] != r_exp_data[7:0]);
        assign w_byte_bad[2*gi+1] = w_exp_keep[2*gi+1] &&
                                    (axis_in_tdata[16*gi+8 +: 8] != r_exp_data[15:8]);
    end

    logic w_data_err;
    logic w_keep_err;
    logic w_len_err;
    logic w_beat_err;
    logic w_accept;
    logic w_lfsr_fb;

    assign w_data_err = |w_byte_bad;
    assign w_keep_err = (axis_in_tkeep != w_exp_keep);
    // Missing tlast can only be seen once per packet: the beat counter
    // passes the expected count exactly once before the resync on tlast.
    assign w_len_err  = (axis_in_tlast && (r_beat < w_exp_beats)) ||
                        (!axis_in_tlast && w_last_exp);
    assign w_beat_err = w_data_err | w_keep_err | w_len_err;
    assign w_accept   = (r_state == S_RUN) && axis_in_tvalid && axis_in_tready;
    // Fibonacci taps 16,14,13,11
    assign w_lfsr_fb  = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state. RUN is only left through reset.
    always_comb begin
        w_state_nxt = r_state;
        if ((r_state == S_IDLE) && start) begin
            w_state_nxt = S_RUN;
        end
    end

    // FSM: outputs
    always_comb begin
        axis_in_tready = 1'b0;
        busy           = 1'b0;
        if (r_state == S_RUN) begin
            busy           = 1'b1;
            axis_in_tready = stall_en ? (r_lfsr[0] | r_lfsr[1]) : 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Checker datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lfsr     <= c_lfsr_seed;
            r_ok       <= '0;
            r_bad      <= '0;
            r_err      <= '0;
            r_exp_data <= '0;
            r_plen_idx <= '0;
            r_beat     <= '0;
            r_pkt_bad  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            if (start) begin
                r_ok       <= '0;
                r_bad      <= '0;
                r_err      <= '0;
                r_exp_data <= 16'd1;
                r_plen_idx <= '0;
                r_beat     <= 13'd1;
                r_pkt_bad  <= 1'b0;
            end
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
            if (w_accept) begin
                r_exp_data <= r_exp_data + 16'd1;
                r_err      <= r_err | {w_len_err, w_keep_err, w_data_err};
                if (axis_in_tlast) begin
                    // Errors on the closing beat count toward this packet
                    if (r_pkt_bad || w_beat_err) begin
                        if (r_bad != '1) begin
                            r_bad <= r_bad + 32'd1;
                        end
                    end else if (r_ok != '1) begin
                        r_ok <= r_ok + 32'd1;
                    end
                    r_plen_idx <= r_plen_idx + 3'd1;
                    r_beat     <= 13'd1;
                    r_pkt_bad  <= 1'b0;
                end else begin
                    // Saturate so an endless packet never aliases back
                    // onto the expected last beat
                    if (r_beat != '1) begin
                        r_beat <= r_beat + 13'd1;
                    end
                    r_pkt_bad <= r_pkt_bad | w_beat_err;
                end
            end
        end
    end

    assign packets_ok  = r_ok;
    assign packets_bad = r_bad;
    assign err_flags   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_packet_check.sv
`default_nettype none
// ============================================================================
//  Module      : tb_packet_check
//  Description : Self-checking bench for packet_check. A table of packet
//                scenarios (clean runs, single faults of each kind, don't-care
//                corruption) is replayed against fixed expected results, a few
//                hand-written sequences cover start-while-running and reset
//                mid-packet, and randomized fault runs are compared against a
//                byte-count reference model of the checking rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_packet_check;

    localparam int DW    = 128;
    localparam int DB    = DW / 8;
    localparam int LANES = DW / 16;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           stall_en;
    logic [DW-1:0]  tdata;
    logic [DB-1:0]  tkeep;
    logic           tlast;
    logic           tvalid;
    logic           tready;
    logic [31:0]    packets_ok;
    logic [31:0]    packets_bad;
    logic [2:0]     err_flags;
    logic           busy;

    always #5 clk = ~clk;

    packet_check #(.DW(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stall_en       (stall_en),
        .axis_in_tdata  (tdata),
        .axis_in_tkeep  (tkeep),
        .axis_in_tlast  (tlast),
        .axis_in_tvalid (tvalid),
        .axis_in_tready (tready),
        .packets_ok     (packets_ok),
        .packets_bad    (packets_bad),
        .err_flags      (err_flags),
        .busy           (busy)
    );

    int lens [8] = '{18, 128, 1021, 205, 12, 127, 329, 256};

    int n_checks = 0;
    int n_fail   = 0;
    int low_seen = 0;

    // Generator state
    logic [15:0] g_data;
    int          g_idx;

    // Reference model state
    logic [15:0] m_exp;
    int          m_idx;
    int          m_beat;
    bit          m_bad;
    int          m_ok_cnt;
    int          m_bad_cnt;
    logic [2:0]  m_err;

    // Fault kinds: 0 none, 1 data XOR on a lane, 2 early tlast,
    // 3 keep XOR, 4 missing tlast (one extra full beat)
    typedef struct {
        bit          stall;
        int          npk;
        int          fpkt;
        int          kind;
        int          fbeat;
        int          flane;
        logic [15:0] fmask;
        int          exp_ok;
        int          exp_bad;
        logic [2:0]  exp_err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_start();
        m_exp = 16'd1; m_idx = 0; m_beat = 1; m_bad = 0;
        m_ok_cnt = 0; m_bad_cnt = 0; m_err = 3'b000;
        g_data = 16'd1; g_idx = 0;
    endtask

    // Rules expressed in bytes remaining in the packet
    task automatic model_beat(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
        int len;
        int nb;
        int rem;
        bit de;
        bit ke;
        bit le;
        bit kept;
        logic [7:0] eb;
        len = lens[m_idx];
        nb  = (len + DB - 1) / DB;
        rem = len - (m_beat - 1) * DB;
        de = 0; ke = 0;
        for (int b = 0; b < DB; b++) begin
            kept = (m_beat > nb) || (b < rem);
            eb   = (b % 2 == 1) ? m_exp[15:8] : m_exp[7:0];
            if (k[b] != kept) ke = 1;
            if (kept && (d[8*b +: 8] != eb)) de = 1;
        end
        le = (l && (m_beat < nb)) || (!l && (m_beat == nb));
        m_err = m_err | {le, ke, de};
        m_exp = m_exp + 16'd1;
        if (l) begin
            if (m_bad || de || ke || le) m_bad_cnt++;
            else m_ok_cnt++;
            m_idx  = (m_idx + 1) % 8;
            m_beat = 1;
            m_bad  = 0;
        end else begin
            m_beat++;
            m_bad = m_bad | de | ke | le;
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [DB-1:0] k, input logic l);
        bit took;
        took   = 0;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tvalid = 1'b1;
        for (int c = 0; c < 200 && !took; c++) begin
            @(negedge clk);
            if (tready) took = 1;
            else low_seen++;
            @(posedge clk);
            #1;
        end
        if (took) begin
            model_beat(d, k, l);
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL beat_accept_timeout: actual=tready_low required=accept");
        end
    endtask

    task automatic send_packet(input int kind, input int fbeat, input int flane, input logic [15:0] fmask);
        int len;
        int nb;
        int part;
        int last_b;
        logic [DW-1:0] d;
        logic [DB-1:0] k;
        len    = lens[g_idx];
        nb     = (len + DB - 1) / DB;
        part   = len % DB;
        last_b = (kind == 4) ? nb + 1 : ((kind == 2) ? fbeat : nb);
        for (int b = 1; b <= last_b; b++) begin
            d = {LANES{g_data}};
            for (int j = 0; j < DB; j++) k[j] = (b != nb) || (part == 0) || (j < part);
            if (kind == 1 && b == fbeat) d[16*flane +: 16] = d[16*flane +: 16] ^ fmask;
            if (kind == 3 && b == fbeat) k = k ^ fmask[DB-1:0];
            send_beat(d, k, b == last_b);
            g_data = g_data + 16'd1;
        end
        tvalid = 1'b0;
        g_idx  = (g_idx + 1) % 8;
    endtask

    task automatic do_reset();
        tvalid = 1'b0; tlast = 1'b0; tkeep = '0; tdata = '0; start = 1'b0;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        model_start();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int kind;
        int nb;
        int fbeat;
        int flane;
        logic [15:0] fmask;

        vecs[0] = '{0, 16, -1, 0, 0,  0, 16'h0000, 16, 0, 3'b000};
        vecs[1] = '{1, 16, -1, 0, 0,  0, 16'h0000, 16, 0, 3'b000};
        vecs[2] = '{0,  8,  1, 1, 5,  3, 16'h0001,  7, 1, 3'b001};
        vecs[3] = '{0,  8,  0, 2, 1,  0, 16'h0000,  7, 1, 3'b100};
        vecs[4] = '{0,  8,  4, 3, 1,  0, 16'hF000,  7, 1, 3'b010};
        vecs[5] = '{1,  8,  0, 4, 0,  0, 16'h0000,  7, 1, 3'b100};
        vecs[6] = '{0,  8,  0, 1, 2,  5, 16'hFFFF,  8, 0, 3'b000};
        vecs[7] = '{1,  8,  2, 1, 64, 6, 16'h0001,  7, 1, 3'b001};
        vecs[8] = '{0,  8,  2, 1, 64, 6, 16'h0100,  8, 0, 3'b000};

        stall_en = 1'b0;
        do_reset();
        check("reset_tready", {31'd0, tready}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ok", packets_ok, 32'd0);
        check("reset_bad", packets_bad, 32'd0);
        check("reset_err", {29'd0, err_flags}, 32'd0);

        // Table-driven scenarios
        for (int v = 0; v < 9; v++) begin
            do_reset();
            stall_en = vecs[v].stall;
            pulse_start();
            low_seen = 0;
            for (int p = 0; p < vecs[v].npk; p++) begin
                if (p == vecs[v].fpkt)
                    send_packet(vecs[v].kind, vecs[v].fbeat, vecs[v].flane, vecs[v].fmask);
                else
                    send_packet(0, 0, 0, 16'h0000);
            end
            idle(4);
            check($sformatf("vec%0d_ok", v), packets_ok, 32'(vecs[v].exp_ok));
            check($sformatf("vec%0d_bad", v), packets_bad, 32'(vecs[v].exp_bad));
            check($sformatf("vec%0d_err", v), {29'd0, err_flags}, {29'd0, vecs[v].exp_err});
            check($sformatf("vec%0d_busy", v), {31'd0, busy}, 32'd1);
            if (vecs[v].stall)
                check($sformatf("vec%0d_tready_low_seen", v), {31'd0, low_seen > 0}, 32'd1);

            // After the first clean pass, start must be ignored in RUN
            if (v == 0) begin
                start = 1'b1;
                idle(1);
                start = 1'b0;
                idle(2);
                check("start_in_run_ok_kept", packets_ok, 32'd16);
                send_packet(0, 0, 0, 16'h0000);
                idle(3);
                check("start_in_run_ok_next", packets_ok, 32'd17);
            end
        end

        // Reset in the middle of packet 2
        do_reset();
        stall_en = 1'b0;
        pulse_start();
        send_packet(0, 0, 0, 16'h0000);
        send_packet(0, 0, 0, 16'h0000);
        for (int b = 0; b < 10; b++) begin
            send_beat({LANES{g_data}}, '1, 1'b0);
            g_data = g_data + 16'd1;
        end
        check("midpkt_before_ok", packets_ok, 32'd2);
        #2 reset = 1'b1;
        #1;
        check("midpkt_reset_tready", {31'd0, tready}, 32'd0);
        check("midpkt_reset_busy", {31'd0, busy}, 32'd0);
        check("midpkt_reset_ok", packets_ok, 32'd0);
        tvalid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        idle(1);
        pulse_start();
        for (int p = 0; p < 8; p++) send_packet(0, 0, 0, 16'h0000);
        idle(4);
        check("rerun_ok", packets_ok, 32'd8);
        check("rerun_bad", packets_bad, 32'd0);
        check("rerun_err", {29'd0, err_flags}, 32'd0);
        check("rerun_busy", {31'd0, busy}, 32'd1);

        // Randomized faults against the reference model
        for (int r = 0; r < 4; r++) begin
            do_reset();
            stall_en = 1'($urandom_range(0, 1));
            pulse_start();
            for (int p = 0; p < 10; p++) begin
                kind  = int'($urandom_range(0, 6));
                if (kind > 4) kind = 0;
                nb    = (lens[g_idx] + DB - 1) / DB;
                fbeat = int'($urandom_range(1, nb));
                flane = int'($urandom_range(0, LANES - 1));
                fmask = 16'($urandom_range(1, 65535));
                if (kind == 2) begin
                    if (nb < 2) kind = 0;
                    else fbeat = int'($urandom_range(1, nb - 1));
                end
                send_packet(kind, fbeat, flane, fmask);
            end
            idle(4);
            check($sformatf("rand%0d_ok", r), packets_ok, 32'(m_ok_cnt));
            check($sformatf("rand%0d_bad", r), packets_bad, 32'(m_bad_cnt));
            check($sformatf("rand%0d_err", r), {29'd0, err_flags}, {29'd0, m_err});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
